// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel enable, syncs, blanking, coordinates, line/frame strobes.
// Optional frame counter built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int CLK_DIV   = 4,
   parameter int COORD_W   = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   output logic               p_tick,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start,
   output logic [15:0]        frame_cnt
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_DISP_C  = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_DISP_C  = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_DISPLAY + H_FP);
   localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_DISPLAY + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_DISPLAY + V_FP);
   localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_DISPLAY + V_FP + V_SYNC);

   logic [DIV_W-1:0]   div_cnt;
   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y_nxt;
   logic               x_wrap;
   logic               y_wrap;
   logic               hsync_nxt;
   logic               vsync_nxt;
   logic               video_on_nxt;

   // Syncs and blanking are decoded from the next counter values so that,
   // once registered, they line up with the x/y registered on the same edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      x_nxt  = x;
      y_nxt  = y;
      x_wrap = p_tick && (x == X_LAST);
      y_wrap = x_wrap && (y == Y_LAST);
      if (p_tick) begin
         if (x_wrap) begin
            x_nxt = '0;
            y_nxt = y_wrap ? '0 : y + COORD_W'(1);
         end else begin
            x_nxt = x + COORD_W'(1);
         end
      end
      hsync_nxt    = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_POL : ~HS_POL;
      vsync_nxt    = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_POL : ~VS_POL;
      video_on_nxt = (x_nxt < H_DISP_C) && (y_nxt < V_DISP_C);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         p_tick      <= 1'b0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         video_on    <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (!en) begin
         div_cnt     <= '0;
         p_tick      <= 1'b0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         video_on    <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         p_tick      <= (div_cnt == DIV_LAST);
         x           <= x_nxt;
         y           <= y_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         video_on    <= video_on_nxt;
         line_start  <= x_wrap;
         frame_start <= y_wrap;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   // Counts on the same edge that raises frame_start, so it reads as frames completed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (!en) begin
         frame_cnt <= '0;
      end else if (y_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   assign frame_cnt = '0;
`endif

endmodule
